// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the parametrised direct-mapped instruction cache.
package icache_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRefill,
      StFlush
   } state_t;

   localparam int unsigned WORD_W = 32;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

   function automatic int unsigned off_w(input int unsigned words_per_line);
      return clog2(words_per_line);
   endfunction

   function automatic int unsigned idx_w(input int unsigned num_sets);
      return clog2(num_sets);
   endfunction

   function automatic int unsigned tag_w(input int unsigned addr_w,
                                         input int unsigned num_sets,
                                         input int unsigned words_per_line);
      return addr_w - 2 - idx_w(num_sets) - off_w(words_per_line);
   endfunction

endpackage

// File: rtl/icache_line_ram.sv
// Synchronous-write, asynchronous-read storage array; used for both cache data and tags.
module icache_line_ram
   import icache_pkg::*;
#(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned WIDTH = 32,
   localparam int unsigned AW   = clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Contents are deliberately not reset; the valid vector qualifies every read.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/icache_dm_param.sv
// Direct-mapped instruction cache with word-serial refill, flush command and saturating miss count.
module icache_dm_param
   import icache_pkg::*;
#(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned NUM_SETS       = 32,
   parameter int unsigned WORDS_PER_LINE = 4,
   parameter int unsigned CNT_W          = 32
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              InstrReq,
   input  logic [ADDR_W-1:0] InstrAddr,
   output logic [31:0]       Instruction,
   output logic              Hit,
   input  logic              Flush,
   output logic              FlushBusy,
   output logic              MemRead,
   output logic [ADDR_W-1:0] MemReadAddr,
   input  logic              DataValid,
   input  logic [31:0]       DataIn,
   output logic [CNT_W-1:0]  MissCount
);

   localparam int unsigned OFF_W = off_w(WORDS_PER_LINE);
   localparam int unsigned IDX_W = idx_w(NUM_SETS);
   localparam int unsigned TAG_W = tag_w(ADDR_W, NUM_SETS, WORDS_PER_LINE);
   localparam int unsigned LINE_WORDS = NUM_SETS * WORDS_PER_LINE;

   state_t                r_state;
   state_t                w_state_next;
   logic [NUM_SETS-1:0]   r_valid;
   logic [OFF_W-1:0]      r_word_cnt;
   logic                  r_flush_pend;
   logic [CNT_W-1:0]      r_miss_cnt;
   logic [TAG_W-1:0]      r_miss_tag;
   logic [IDX_W-1:0]      r_miss_idx;
   logic                  r_mem_read;
   logic [ADDR_W-1:0]     r_mem_addr;

   logic [TAG_W-1:0]      w_tag;
   logic [IDX_W-1:0]      w_idx;
   logic [OFF_W-1:0]      w_off;
   logic [TAG_W-1:0]      w_tag_rd;
   logic [WORD_W-1:0]     w_data_rd;
   logic                  w_hit;
   logic                  w_miss;
   logic                  w_fill_we;
   logic                  w_fill_last;
   logic [OFF_W-1:0]      w_cnt_inc;
   logic                  w_unused_addr;

   assign w_tag         = InstrAddr[ADDR_W-1 -: TAG_W];
   assign w_idx         = InstrAddr[2+OFF_W +: IDX_W];
   assign w_off         = InstrAddr[2 +: OFF_W];
   assign w_unused_addr = ^InstrAddr[1:0];

   icache_line_ram #(
      .DEPTH (LINE_WORDS),
      .WIDTH (WORD_W)
   ) u_data_ram (
      .i_clk   (CLK),
      .i_we    (w_fill_we),
      .i_waddr ({r_miss_idx, r_word_cnt}),
      .i_wdata (DataIn),
      .i_raddr ({w_idx, w_off}),
      .o_rdata (w_data_rd)
   );

   icache_line_ram #(
      .DEPTH (NUM_SETS),
      .WIDTH (TAG_W)
   ) u_tag_ram (
      .i_clk   (CLK),
      .i_we    (w_fill_last),
      .i_waddr (r_miss_idx),
      .i_wdata (r_miss_tag),
      .i_raddr (w_idx),
      .o_rdata (w_tag_rd)
   );

   assign w_hit = (r_state == StIdle) & InstrReq & r_valid[w_idx] & (w_tag_rd == w_tag);

   // Memory data is only accepted while a request is outstanding.
   assign w_fill_we   = (r_state == StRefill) & DataValid;
   assign w_fill_last = w_fill_we & (&r_word_cnt);
   assign w_cnt_inc   = r_word_cnt + OFF_W'(1);

   always_comb begin
      w_state_next = r_state;
      w_miss       = 1'b0;
      case (r_state)
         StIdle: begin
            if (Flush | r_flush_pend) begin
               w_state_next = StFlush;
            end else if (InstrReq & ~w_hit) begin
               w_state_next = StRefill;
               w_miss       = 1'b1;
            end
         end
         StRefill: begin
            if (w_fill_last) begin
               w_state_next = StIdle;
            end
         end
         StFlush: begin
            w_state_next = StIdle;
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_state      <= StIdle;
         r_valid      <= '0;
         r_word_cnt   <= '0;
         r_flush_pend <= 1'b0;
         r_miss_cnt   <= '0;
         r_miss_tag   <= '0;
         r_miss_idx   <= '0;
         r_mem_read   <= 1'b0;
         r_mem_addr   <= '0;
      end else begin
         r_state <= w_state_next;

         // A new pulse wins over the clear so back-to-back flushes are not lost.
         if (Flush) begin
            r_flush_pend <= 1'b1;
         end else if (r_state == StFlush) begin
            r_flush_pend <= 1'b0;
         end

         if (r_state == StFlush) begin
            r_valid <= '0;
         end else if (w_miss) begin
            r_valid[w_idx] <= 1'b0;
            r_miss_tag     <= w_tag;
            r_miss_idx     <= w_idx;
            r_word_cnt     <= '0;
            r_mem_read     <= 1'b1;
            r_mem_addr     <= {w_tag, w_idx, {OFF_W{1'b0}}, 2'b00};
            if (~&r_miss_cnt) begin
               r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            end
         end else if (w_fill_we) begin
            r_word_cnt <= w_cnt_inc;
            if (w_fill_last) begin
               r_valid[r_miss_idx] <= 1'b1;
               r_mem_read          <= 1'b0;
               r_mem_addr          <= '0;
            end else begin
               r_mem_addr <= {r_miss_tag, r_miss_idx, w_cnt_inc, 2'b00};
            end
         end
      end
   end

   assign Hit         = w_hit;
   assign Instruction = w_hit ? w_data_rd : '0;
   assign FlushBusy   = r_flush_pend | (r_state == StFlush);
   assign MemRead     = r_mem_read;
   assign MemReadAddr = r_mem_addr;
   assign MissCount   = r_miss_cnt;

endmodule

// File: tb/tb_icache_dm_param.sv
// Directed bench: default-geometry cache (tests 1-5) plus an 8-word, 64-set instance (test 6).
module tb_icache_dm_param;

   logic clk;
   logic rst;

   logic        a_req, a_flush, a_dv;
   logic [31:0] a_addr, a_din, a_instr, a_maddr, a_mcnt;
   logic        a_hit, a_fbusy, a_mrd;

   logic        b_req, b_flush, b_dv;
   logic [31:0] b_addr, b_din, b_instr, b_maddr, b_mcnt;
   logic        b_hit, b_fbusy, b_mrd;

   int n_checks = 0;
   int n_errors = 0;
   int n_hs     = 0;

   icache_dm_param u_dut_a (
      .CLK         (clk),
      .Reset       (rst),
      .InstrReq    (a_req),
      .InstrAddr   (a_addr),
      .Instruction (a_instr),
      .Hit         (a_hit),
      .Flush       (a_flush),
      .FlushBusy   (a_fbusy),
      .MemRead     (a_mrd),
      .MemReadAddr (a_maddr),
      .DataValid   (a_dv),
      .DataIn      (a_din),
      .MissCount   (a_mcnt)
   );

   icache_dm_param #(
      .ADDR_W         (32),
      .NUM_SETS       (64),
      .WORDS_PER_LINE (8),
      .CNT_W          (32)
   ) u_dut_b (
      .CLK         (clk),
      .Reset       (rst),
      .InstrReq    (b_req),
      .InstrAddr   (b_addr),
      .Instruction (b_instr),
      .Hit         (b_hit),
      .Flush       (b_flush),
      .FlushBusy   (b_fbusy),
      .MemRead     (b_mrd),
      .MemReadAddr (b_maddr),
      .DataValid   (b_dv),
      .DataIn      (b_din),
      .MissCount   (b_mcnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Entered at the negedge after the miss edge; leaves at the negedge after the last word.
   task automatic refill_a(input logic [31:0] base, input logic [31:0] dbase,
                           input int stall, input int flush_w);
      for (int w = 0; w < 4; w++) begin
         for (int s = 0; s < stall; s++) begin
            a_dv    = 1'b0;
            a_flush = (w == flush_w) && (s == 0);
            #1;
            check_eq($sformatf("stall_mrd w%0d s%0d", w, s), 32'(a_mrd), 32'd1);
            check_eq($sformatf("stall_addr w%0d s%0d", w, s), a_maddr, base + 32'(4 * w));
            check_eq($sformatf("stall_hit w%0d s%0d", w, s), 32'(a_hit), 32'd0);
            @(negedge clk);
         end
         a_flush = 1'b0;
         a_dv    = 1'b1;
         a_din   = dbase + 32'(w);
         #1;
         check_eq($sformatf("fill_mrd w%0d", w), 32'(a_mrd), 32'd1);
         check_eq($sformatf("fill_addr w%0d", w), a_maddr, base + 32'(4 * w));
         if (a_dv && a_mrd) n_hs++;
         @(negedge clk);
      end
      a_dv = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      a_req = 0; a_flush = 0; a_dv = 0; a_addr = '0; a_din = '0;
      b_req = 0; b_flush = 0; b_dv = 0; b_addr = '0; b_din = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("rst_hit", 32'(a_hit), 32'd0);
      check_eq("rst_instr", a_instr, 32'd0);
      check_eq("rst_mrd", 32'(a_mrd), 32'd0);
      check_eq("rst_maddr", a_maddr, 32'd0);
      check_eq("rst_mcnt", a_mcnt, 32'd0);
      check_eq("rst_fbusy", 32'(a_fbusy), 32'd0);

      // Test 1: cold miss on 0x100, in-order refill, then hits.
      a_req = 1'b1; a_addr = 32'h100;
      #1 check_eq("t1_first_hit", 32'(a_hit), 32'd0);
      @(negedge clk);
      check_eq("t1_mcnt", a_mcnt, 32'd1);
      refill_a(32'h100, 32'hA0, 0, -1);
      #1;
      check_eq("t1_mrd_done", 32'(a_mrd), 32'd0);
      check_eq("t1_maddr_done", a_maddr, 32'd0);
      check_eq("t1_hit", 32'(a_hit), 32'd1);
      check_eq("t1_instr0", a_instr, 32'hA0);
      a_addr = 32'h108;
      #1 check_eq("t1_instr2", a_instr, 32'hA2);
      a_req = 1'b0;
      #1 check_eq("t1_noreq_hit", 32'(a_hit), 32'd0);
      check_eq("t1_noreq_instr", a_instr, 32'd0);
      a_req = 1'b1;

      // Test 2: conflicting tag on index 16 evicts 0x100.
      a_addr = 32'h300;
      #1 check_eq("t2_miss", 32'(a_hit), 32'd0);
      @(negedge clk);
      check_eq("t2_mcnt", a_mcnt, 32'd2);
      refill_a(32'h300, 32'hB0, 0, -1);
      a_addr = 32'h30C;
      #1 check_eq("t2_instr3", a_instr, 32'hB3);
      a_addr = 32'h100;
      #1 check_eq("t2_evicted", 32'(a_hit), 32'd0);
      @(negedge clk);
      check_eq("t2_mcnt3", a_mcnt, 32'd3);

      // Test 3: memory stalls 5 cycles before each word.
      n_hs = 0;
      refill_a(32'h100, 32'hC0, 5, -1);
      check_eq("t3_handshakes", 32'(n_hs), 32'd4);
      for (int w = 0; w < 4; w++) begin
         a_addr = 32'h100 + 32'(4 * w);
         #1 check_eq($sformatf("t3_word%0d", w), a_instr, 32'hC0 + 32'(w));
      end
      @(negedge clk);
      check_eq("t3_mcnt", a_mcnt, 32'd3);

      // Test 4: flush pulse while waiting on word 2.
      a_addr = 32'h200;
      #1 check_eq("t4_miss", 32'(a_hit), 32'd0);
      @(negedge clk);
      check_eq("t4_mcnt", a_mcnt, 32'd4);
      refill_a(32'h200, 32'hF0, 2, 2);
      #1;
      check_eq("t4_busy_pend", 32'(a_fbusy), 32'd1);
      check_eq("t4_mrd_done", 32'(a_mrd), 32'd0);
      @(negedge clk);
      check_eq("t4_busy_flush", 32'(a_fbusy), 32'd1);
      check_eq("t4_hit_flush", 32'(a_hit), 32'd0);
      check_eq("t4_mcnt_flush", a_mcnt, 32'd4);
      a_req = 1'b0;
      @(negedge clk);
      check_eq("t4_busy_done", 32'(a_fbusy), 32'd0);
      a_req = 1'b1;
      #1 check_eq("t4_200_gone", 32'(a_hit), 32'd0);
      a_addr = 32'h100;
      #1 check_eq("t4_100_gone", 32'(a_hit), 32'd0);
      @(negedge clk);
      check_eq("t4_mcnt5", a_mcnt, 32'd5);
      check_eq("t4_mrd", 32'(a_mrd), 32'd1);

      // Test 5: reset after word 1 of the 0x100 refill.
      a_dv = 1'b1; a_din = 32'hD0;
      @(negedge clk);
      a_din = 32'hD1;
      @(negedge clk);
      check_eq("t5_addr_w2", a_maddr, 32'h108);
      a_dv = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("t5_mrd", 32'(a_mrd), 32'd0);
      check_eq("t5_maddr", a_maddr, 32'd0);
      check_eq("t5_mcnt", a_mcnt, 32'd0);
      a_req = 1'b0; a_dv = 1'b1; a_din = 32'hDEAD;
      @(negedge clk);
      check_eq("t5_stray_mrd", 32'(a_mrd), 32'd0);
      check_eq("t5_stray_mcnt", a_mcnt, 32'd0);
      a_dv = 1'b0; a_req = 1'b1; a_addr = 32'h100;
      #1 check_eq("t5_miss", 32'(a_hit), 32'd0);
      @(negedge clk);
      check_eq("t5_mcnt1", a_mcnt, 32'd1);
      check_eq("t5_req_addr", a_maddr, 32'h100);
      refill_a(32'h100, 32'hE0, 0, -1);
      a_addr = 32'h104;
      #1 check_eq("t5_instr1", a_instr, 32'hE1);

      // Test 6: 8-word lines, 64 sets.
      b_req = 1'b1; b_addr = 32'h2000_0040;
      #1 check_eq("t6_miss", 32'(b_hit), 32'd0);
      @(negedge clk);
      check_eq("t6_mcnt", b_mcnt, 32'd1);
      for (int w = 0; w < 8; w++) begin
         b_dv = 1'b1; b_din = 32'h60 + 32'(w);
         #1;
         check_eq($sformatf("t6_mrd w%0d", w), 32'(b_mrd), 32'd1);
         check_eq($sformatf("t6_addr w%0d", w), b_maddr, 32'h2000_0040 + 32'(4 * w));
         @(negedge clk);
      end
      b_dv = 1'b0;
      #1 check_eq("t6_mrd_done", 32'(b_mrd), 32'd0);
      b_addr = 32'h2000_0058;
      #1;
      check_eq("t6_hit", 32'(b_hit), 32'd1);
      check_eq("t6_word6", b_instr, 32'h66);
      b_addr = 32'h2000_0040;
      #1 check_eq("t6_word0", b_instr, 32'h60);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
